shift_seq: RTL
==============

Name: shift_seq

Overview:
- Multi-cycle shift sequencer that owns one shift_reg instance and performs "op by amount" commands on it.
- Accepts a command (op, amount, data, serial bit) over a valid/ready handshake.
- Loads the register, issues the shift control code once per cycle for `amount` cycles, then presents the result over a valid/ready response handshake.
- Sits between a CPU-side requester and the shift datapath, so the requester never drives shift_reg controls directly.

Parameters:
- N, 8, data width of shift_reg and of the command/response data.
- CW, $clog2(N)+1, width of the shift-amount field (N=8 gives 4 bits, so 0..15 steps).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_op  in  3  shift_reg control code: 000 clr, 001 load, 010 srl, 011 sll, 100 sra, 101 serial-in right, 110 ror, 111 rol.
- cmd_amt  in  CW  number of single-bit steps.
- cmd_data  in  N  initial register value.
- cmd_sin  in  1  serial bit shifted into the MSB for op 101.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  requester takes the result.
- rsp_data  out  N  result; equals shift_reg data_out in DONE, 0 otherwise.
- busy  out  1  high in LOAD or SHIFT.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Reset (rst_n low, asynchronous) forces IDLE, clears the step counter and the captured op/amt/sin. Outputs while in reset and in IDLE: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Hold: shift_reg has no hold code. In IDLE and DONE the controller drives ctrl=001 with data_in=data_out so the contents stay stable.
- IDLE: on cmd_valid&&cmd_ready at edge k, capture op, amt, data and sin, and go to LOAD. cmd_valid with cmd_ready low is ignored; no queueing.
- LOAD (one cycle):
  - Drives ctrl=001 with data_in=captured data. For op 000 it drives ctrl=000 instead.
  - Next state is DONE if op is 000 or 001 or amt==0; otherwise SHIFT with counter=amt.
- SHIFT:
  - Drives ctrl=captured op and instream=captured sin; the counter decrements each cycle.
  - Exactly amt steps occur. Go to DONE on the edge where the counter goes 1->0.
- DONE: rsp_valid=1 and rsp_data=data_out, both stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE. cmd_ready=0 in DONE, so the earliest next accept is the cycle after the response handshake.
- Latency: with accept at edge k, rsp_valid is first high in cycle k+2+amt (k+2 for ops 000/001 or amt==0).
- Amounts above N are not clamped: rotates wrap, logical shifts saturate to 0, sra saturates to all-sign, op 101 fills with sin.
- Reset mid-operation aborts the command: no response is issued, the shift_reg contents are don't-care, and cmd_ready=1 on the first cycle after release.
- Op semantics (inherited from shift_reg):
  - 010: MSB<-0.
  - 011: LSB<-0.
  - 100: MSB kept.
  - 101: MSB<-sin.
  - 110: LSB->MSB.
  - 111: MSB->LSB.

Decomposition:
- Shared package shift_pkg holds:
  - SR_CLR..SR_ROL 3-bit localparams for the eight ctrl codes.
  - The state enum (IDLE, LOAD, SHIFT, DONE, 2 bits).
- shift_seq instantiates the existing shift_reg (#(.N(N))) as its single sub-module. The FSM and counter stay in shift_seq.

Test Plan (N=8):
- op=010, amt=3, data=8'b1011_0110 -> rsp_data=8'b0001_0110; rsp_valid first high 5 cycles after the accept edge; busy high for 4 cycles.
- op=100, amt=2, data=8'b1000_0001 -> 8'b1110_0000. op=011, amt=15, data=8'hFF -> 8'h00.
- op=110, amt=8, data=8'hA5 -> 8'hA5. op=111, amt=1, data=8'h81 -> 8'h03.
- op=101, sin=1, amt=4, data=8'h00 -> 8'hF0. op=000 with data=8'h5A -> 8'h00 at accept+2.
- op=011, amt=0, data=8'h3C -> 8'h3C at accept+2. Hold rsp_ready low for 3 cycles: rsp_data stays 8'h3C, cmd_ready=0, and a cmd_valid pulse is ignored.
- Assert rst_n=0 asynchronously mid-SHIFT (op=010, amt=6) -> rsp_valid=0, busy=0 and cmd_ready=1 immediately. The next command, op=001 data=8'h77, returns 8'h77.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift_reg control codes and sequencer state encoding
package shift_pkg;

  localparam logic [2:0] SR_CLR  = 3'b000;
  localparam logic [2:0] SR_LOAD = 3'b001;
  localparam logic [2:0] SR_SRL  = 3'b010;
  localparam logic [2:0] SR_SLL  = 3'b011;
  localparam logic [2:0] SR_SRA  = 3'b100;
  localparam logic [2:0] SR_SIN  = 3'b101;
  localparam logic [2:0] SR_ROR  = 3'b110;
  localparam logic [2:0] SR_ROL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_reg.sv
// rtl/shift_reg.sv - N-bit shift register with eight single-step control codes
module shift_reg
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   ctrl,
  input  logic [N-1:0] data_in,
  input  logic         instream,
  output logic [N-1:0] data_out
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      case (ctrl)
        SR_CLR:  r_q <= '0;
        SR_LOAD: r_q <= data_in;
        SR_SRL:  r_q <= {1'b0, r_q[N-1:1]};
        SR_SLL:  r_q <= {r_q[N-2:0], 1'b0};
        SR_SRA:  r_q <= {r_q[N-1], r_q[N-1:1]};
        SR_SIN:  r_q <= {instream, r_q[N-1:1]};
        SR_ROR:  r_q <= {r_q[0], r_q[N-1:1]};
        SR_ROL:  r_q <= {r_q[N-2:0], r_q[N-1]};
        default: r_q <= r_q;
      endcase
    end
  end

  assign data_out = r_q;

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle "op by amount" sequencer around one shift_reg
module shift_seq
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_amt,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_sin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          busy
);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [CW-1:0] r_amt;
  logic          r_sin;
  logic [N-1:0]  r_data;

  logic [2:0]    w_ctrl;
  logic [N-1:0]  w_data_in;
  logic          w_instream;
  logic [N-1:0]  w_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_amt   <= '0;
      r_sin   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_amt   <= cmd_amt;
            r_sin   <= cmd_sin;
            r_data  <= cmd_data;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (r_op == SR_CLR || r_op == SR_LOAD || r_amt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt   <= r_amt;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // No hold code exists, so idle/done reload the register with its own value.
  always_comb begin
    w_ctrl     = SR_LOAD;
    w_data_in  = w_data_out;
    w_instream = 1'b0;
    case (r_state)
      LOAD: begin
        w_ctrl    = (r_op == SR_CLR) ? SR_CLR : SR_LOAD;
        w_data_in = r_data;
      end
      SHIFT: begin
        w_ctrl     = r_op;
        w_instream = r_sin;
      end
      default: ;
    endcase
  end

  shift_reg #(.N(N)) u_shift_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (w_ctrl),
    .data_in  (w_data_in),
    .instream (w_instream),
    .data_out (w_data_out)
  );

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state == LOAD) || (r_state == SHIFT);
  assign rsp_data  = (r_state == DONE) ? w_data_out : '0;

endmodule
